// File: rtl/grf_wr_arbiter_if.sv
// Bus bundle for the GRF write-port arbiter: source A (writeback), source B
// (long-latency return, valid/ready) and the registered GRF write port.
interface grf_wr_arbiter_if #(
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    // source A: fixed priority, no backpressure
    logic          a_valid;
    logic [31:0]   a_pc;
    logic [4:0]    a_addr;
    logic [31:0]   a_data;

    // source B: valid/ready into the FIFO
    logic          b_valid;
    logic          b_ready;
    logic [31:0]   b_pc;
    logic [4:0]    b_addr;
    logic [31:0]   b_data;

    // GRF write port and status
    logic          we3;
    logic [4:0]    a3;
    logic [31:0]   wd3;
    logic [31:0]   pc;
    logic          stall_req;
    logic [CW-1:0] b_count;

    // requester side (pipeline + B source + GRF)
    modport master (
        output a_valid, a_pc, a_addr, a_data,
        output b_valid, b_pc, b_addr, b_data,
        input  b_ready, we3, a3, wd3, pc, stall_req, b_count
    );

    // arbiter side
    modport slave (
        input  a_valid, a_pc, a_addr, a_data,
        input  b_valid, b_pc, b_addr, b_data,
        output b_ready, we3, a3, wd3, pc, stall_req, b_count
    );
endinterface

// File: rtl/grf_wr_arbiter.sv
// GRF write-port arbiter. A (writeback) has fixed priority; B writes are
// queued in a small FIFO and drained when A is idle. A saturating starvation
// counter raises stall_req so the pipeline yields a slot to the B head.
module grf_wr_arbiter #(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic             clk,
    input  logic             reset,
    grf_wr_arbiter_if.slave  bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    localparam logic [1:0] GRANT_IDLE = 2'd0;
    localparam logic [1:0] GRANT_A    = 2'd1;
    localparam logic [1:0] GRANT_B    = 2'd2;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_req_t;

    wr_req_t        fifo_mem [DEPTH];
    logic [PW-1:0]  rd_ptr;
    logic [PW-1:0]  wr_ptr;
    logic [CW-1:0]  count;
    logic [SW-1:0]  starve_cnt;

    logic           we3_q;
    logic [4:0]     a3_q;
    logic [31:0]    wd3_q;
    logic [31:0]    pc_q;

    logic [1:0]     grant;
    logic           fifo_empty;
    logic           fifo_full;
    logic           stall;
    logic           enq;
    logic           deq;
    wr_req_t        a_req;
    wr_req_t        b_req;
    wr_req_t        head;

    assign a_req      = '{pc: bus.a_pc, addr: bus.a_addr, data: bus.a_data};
    assign b_req      = '{pc: bus.b_pc, addr: bus.b_addr, data: bus.b_data};
    assign head       = fifo_mem[rd_ptr];

    // status comes from registers only, never from the current inputs
    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == CW'(DEPTH));
    assign stall      = (starve_cnt == SW'(STARVE_LIMIT));

    assign bus.b_ready   = !fifo_full;
    assign bus.stall_req = stall;
    assign bus.b_count   = count;
    assign bus.we3       = we3_q;
    assign bus.a3        = a3_q;
    assign bus.wd3       = wd3_q;
    assign bus.pc        = pc_q;

    // a full FIFO refuses enqueue even if the head leaves this cycle
    assign enq = bus.b_valid && !fifo_full;
    assign deq = (grant == GRANT_B);

    // grant: forced B under stall, else A priority, else drain B
    always_comb begin
        grant = GRANT_IDLE;
        if (stall && !fifo_empty)
            grant = GRANT_B;
        else if (bus.a_valid)
            grant = GRANT_A;
        else if (!fifo_empty)
            grant = GRANT_B;
    end

    // FIFO storage: payload only, validity is tracked by pointers/count
    always_ff @(posedge clk) begin
        if (enq)
            fifo_mem[wr_ptr] <= b_req;
    end

    // FIFO pointers and occupancy; pointers wrap on the power-of-two depth
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (enq)
                wr_ptr <= wr_ptr + 1'b1;
            if (deq)
                rd_ptr <= rd_ptr + 1'b1;
            case ({enq, deq})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // starvation counter: counts A wins over a waiting B head, saturates
    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (grant == GRANT_B || fifo_empty) begin
            starve_cnt <= '0;
        end else if (grant == GRANT_A && !stall) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

    // registered GRF write port; idle keeps the last address/data/pc
    always_ff @(posedge clk) begin
        if (reset) begin
            we3_q <= 1'b0;
            a3_q  <= '0;
            wd3_q <= '0;
            pc_q  <= '0;
        end else begin
            case (grant)
                GRANT_A: begin
                    we3_q <= 1'b1;
                    a3_q  <= a_req.addr;
                    wd3_q <= a_req.data;
                    pc_q  <= a_req.pc;
                end
                GRANT_B: begin
                    we3_q <= 1'b1;
                    a3_q  <= head.addr;
                    wd3_q <= head.data;
                    pc_q  <= head.pc;
                end
                default: we3_q <= 1'b0;
            endcase
        end
    end
endmodule

// File: tb/tb_grf_wr_arbiter.sv
// Bench for grf_wr_arbiter: directed scenarios plus a randomized run, all
// checked against a queue-based reference model of the arbitration rules.
module tb_grf_wr_arbiter;
    localparam int DEPTH = 4;
    localparam int LIMIT = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    grf_wr_arbiter_if #(.DEPTH(DEPTH)) bus ();

    grf_wr_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int nvec = 0;
    int nbad = 0;

    // reference model state
    logic [68:0] mq[$];
    int          m_starve;
    logic        m_we;
    logic [4:0]  m_a3;
    logic [31:0] m_wd;
    logic [31:0] m_pc;

    function automatic logic [74:0] model_vec();
        return {m_we, m_a3, m_wd, m_pc, 3'(mq.size()),
                (mq.size() != DEPTH), (m_starve == LIMIT)};
    endfunction

    function automatic logic [74:0] dut_vec();
        return {bus.we3, bus.a3, bus.wd3, bus.pc, bus.b_count,
                bus.b_ready, bus.stall_req};
    endfunction

    // one clock: drive on negedge, advance the model at posedge, settle
    task automatic step(input logic rst,
                        input logic av, input logic [4:0] aad,
                        input logic [31:0] ad, input logic [31:0] apc,
                        input logic bv, input logic [4:0] bad,
                        input logic [31:0] bd, input logic [31:0] bpc);
        bit stall, nonempty, ready, ga, gb;
        logic [68:0] h;
        @(negedge clk);
        reset = rst;
        bus.a_valid = av; bus.a_addr = aad; bus.a_data = ad; bus.a_pc = apc;
        bus.b_valid = bv; bus.b_addr = bad; bus.b_data = bd; bus.b_pc = bpc;
        @(posedge clk);
        if (rst) begin
            mq.delete();
            m_starve = 0;
            m_we = 1'b0; m_a3 = '0; m_wd = '0; m_pc = '0;
        end else begin
            stall    = (m_starve == LIMIT);
            nonempty = (mq.size() != 0);
            ready    = (mq.size() != DEPTH);
            gb = (stall && nonempty) || (!av && nonempty);
            ga = !gb && av;
            if (gb) begin
                h = mq.pop_front();
                m_we = 1'b1;
                {m_pc, m_a3, m_wd} = h;
            end else if (ga) begin
                m_we = 1'b1; m_pc = apc; m_a3 = aad; m_wd = ad;
            end else begin
                m_we = 1'b0;
            end
            if (gb || !nonempty) m_starve = 0;
            else if (ga && m_starve < LIMIT) m_starve++;
            if (bv && ready) mq.push_back({bpc, bad, bd});
        end
        #1;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0, 32'd0);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++)
            step(1'b1, 1'($urandom), 5'($urandom), $urandom, $urandom,
                 1'($urandom), 5'($urandom), $urandom, $urandom);
        nvec++;
        if (dut_vec() !== {1'b0, 5'd0, 32'd0, 32'd0, 3'd0, 1'b1, 1'b0}) begin
            nbad++;
            $display("FAIL reset: got %h want %h", dut_vec(),
                     {1'b0, 5'd0, 32'd0, 32'd0, 3'd0, 1'b1, 1'b0});
        end
    endtask

    task automatic test_a_only();
        step(1'b0, 1'b1, 5'd5, 32'h1234, 32'h3000, 1'b0, 5'd0, 32'd0, 32'd0);
        nvec++;
        if ({bus.we3, bus.a3, bus.wd3, bus.pc} !== {1'b1, 5'd5, 32'h1234, 32'h3000}) begin
            nbad++;
            $display("FAIL a_only_write: got we=%b a3=%0d wd=%h pc=%h want 1/5/1234/3000",
                     bus.we3, bus.a3, bus.wd3, bus.pc);
        end
        idle();
        nvec++;
        if (bus.we3 !== 1'b0 || bus.a3 !== 5'd5) begin
            nbad++;
            $display("FAIL a_only_idle: got we=%b a3=%0d want 0/5", bus.we3, bus.a3);
        end
    endtask

    task automatic test_b_fill_drain();
        logic [2:0] exp_cnt [5] = '{3'd3, 3'd3, 3'd2, 3'd1, 3'd0};
        // A busy on $0 keeps the FIFO from draining while it fills
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b1, 5'd0, 32'h0, 32'h2000,
                 1'b1, 5'(10 + i), 32'hB000_0000 + i, 32'h4000 + 4 * i);
            nvec++;
            if (bus.b_count !== 3'(i < 4 ? i + 1 : 4) || bus.b_ready !== (i < 3)) begin
                nbad++;
                $display("FAIL fill_%0d: got cnt=%0d rdy=%b want cnt=%0d rdy=%b",
                         i, bus.b_count, bus.b_ready, (i < 4 ? i + 1 : 4), (i < 3));
            end
        end
        // A idle: drain in order; the refused 5th entry is held until accepted
        for (int k = 0; k < 5; k++) begin
            step(1'b0, 1'b0, 5'd0, 32'd0, 32'd0,
                 (k < 2), 5'd14, 32'hB000_0004, 32'h4010);
            nvec++;
            if (bus.we3 !== 1'b1 || bus.wd3 !== 32'hB000_0000 + k ||
                bus.a3 !== 5'(10 + k) || bus.b_count !== exp_cnt[k] || bus.b_ready !== 1'b1) begin
                nbad++;
                $display("FAIL drain_%0d: got we=%b a3=%0d wd=%h cnt=%0d rdy=%b want 1/%0d/%h/%0d/1",
                         k, bus.we3, bus.a3, bus.wd3, bus.b_count, bus.b_ready,
                         10 + k, 32'hB000_0000 + k, exp_cnt[k]);
            end
        end
        idle();
        nvec++;
        if (dut_vec() !== model_vec() || bus.we3 !== 1'b0) begin
            nbad++;
            $display("FAIL drain_done: got %h want %h", dut_vec(), model_vec());
        end
    endtask

    task automatic test_collision();
        step(1'b0, 1'b1, 5'd8, 32'hAAAA, 32'h5000, 1'b1, 5'd8, 32'hBBBB, 32'h6000);
        nvec++;
        if ({bus.we3, bus.a3, bus.wd3} !== {1'b1, 5'd8, 32'hAAAA}) begin
            nbad++;
            $display("FAIL collide_a: got we=%b a3=%0d wd=%h want 1/8/aaaa", bus.we3, bus.a3, bus.wd3);
        end
        idle();
        nvec++;
        if ({bus.we3, bus.a3, bus.wd3, bus.pc} !== {1'b1, 5'd8, 32'hBBBB, 32'h6000}) begin
            nbad++;
            $display("FAIL collide_b: got we=%b a3=%0d wd=%h pc=%h want 1/8/bbbb/6000",
                     bus.we3, bus.a3, bus.wd3, bus.pc);
        end
    endtask

    task automatic test_starvation();
        step(1'b0, 1'b1, 5'd0, 32'h100, 32'h8000, 1'b1, 5'd3, 32'hC0DE, 32'h7000);
        for (int j = 1; j <= LIMIT; j++) begin
            step(1'b0, 1'b1, 5'd0, 32'h100 + j, 32'h8000, 1'b0, 5'd0, 32'd0, 32'd0);
            nvec++;
            if (bus.stall_req !== (j == LIMIT) || bus.wd3 !== 32'h100 + j || bus.b_count !== 3'd1) begin
                nbad++;
                $display("FAIL starve_%0d: got stall=%b wd=%h cnt=%0d want %b/%h/1",
                         j, bus.stall_req, bus.wd3, bus.b_count, (j == LIMIT), 32'h100 + j);
            end
        end
        // a_valid stays high under stall: B head still wins
        step(1'b0, 1'b1, 5'd0, 32'h999, 32'h8000, 1'b0, 5'd0, 32'd0, 32'd0);
        nvec++;
        if ({bus.we3, bus.a3, bus.wd3, bus.pc, bus.stall_req, bus.b_count} !==
            {1'b1, 5'd3, 32'hC0DE, 32'h7000, 1'b0, 3'd0}) begin
            nbad++;
            $display("FAIL starve_grant: got we=%b a3=%0d wd=%h pc=%h stall=%b cnt=%0d want 1/3/c0de/7000/0/0",
                     bus.we3, bus.a3, bus.wd3, bus.pc, bus.stall_req, bus.b_count);
        end
    endtask

    task automatic test_reset_mid_drain();
        for (int i = 0; i < 3; i++)
            step(1'b0, 1'b1, 5'd0, 32'h0, 32'h9000,
                 1'b1, 5'd20, 32'hDEAD_0000 + i, 32'hA000);
        nvec++;
        if (bus.b_count !== 3'd3) begin
            nbad++;
            $display("FAIL rmd_fill: got cnt=%0d want 3", bus.b_count);
        end
        step(1'b1, 1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0, 32'd0);
        nvec++;
        if (bus.b_count !== 3'd0 || bus.we3 !== 1'b0 || bus.b_ready !== 1'b1) begin
            nbad++;
            $display("FAIL rmd_reset: got cnt=%0d we=%b rdy=%b want 0/0/1",
                     bus.b_count, bus.we3, bus.b_ready);
        end
        for (int k = 0; k < 6; k++) begin
            idle();
            nvec++;
            if (bus.we3 !== 1'b0 || bus.wd3[31:16] === 16'hDEAD) begin
                nbad++;
                $display("FAIL rmd_leak_%0d: got we=%b wd=%h want we=0", k, bus.we3, bus.wd3);
            end
        end
    endtask

    task automatic test_random();
        logic av, bv, rst;
        for (int n = 0; n < 600; n++) begin
            rst = ($urandom_range(0, 99) == 0);
            // pipeline honours stall_req; A is busy most cycles to provoke starvation
            av  = (m_starve != LIMIT) && ($urandom_range(0, 3) != 0);
            bv  = 1'($urandom);
            step(rst, av, 5'($urandom), $urandom, $urandom,
                 bv, 5'($urandom), $urandom, $urandom);
            nvec++;
            if (dut_vec() !== model_vec()) begin
                nbad++;
                $display("FAIL random_%0d: got %h want %h", n, dut_vec(), model_vec());
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        bus.a_valid = 1'b0; bus.a_addr = '0; bus.a_data = '0; bus.a_pc = '0;
        bus.b_valid = 1'b0; bus.b_addr = '0; bus.b_data = '0; bus.b_pc = '0;
        test_reset();
        test_a_only();
        test_b_fill_drain();
        test_collision();
        test_starvation();
        test_reset_mid_drain();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end
endmodule
